// File: rtl/decode_queue_if.sv
// OP_* codes emitted by decode_queue, and the fetch/dispatch handshake bundle around it.
// The slave modport is the queue's view; master is the fetch/dispatch environment.
package decode_queue_pkg;

  typedef enum logic [5:0] {
    OP_NONE  = 6'd0,
    OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10,
    OP_LB    = 6'd11, OP_LH    = 6'd12, OP_LW    = 6'd13, OP_LBU   = 6'd14,
    OP_LHU   = 6'd15,
    OP_SB    = 6'd16, OP_SH    = 6'd17, OP_SW    = 6'd18,
    OP_ADDI  = 6'd19, OP_SLTI  = 6'd20, OP_SLTIU = 6'd21, OP_XORI  = 6'd22,
    OP_ORI   = 6'd23, OP_ANDI  = 6'd24, OP_SLLI  = 6'd25, OP_SRLI  = 6'd26,
    OP_SRAI  = 6'd27,
    OP_ADD   = 6'd28, OP_SUB   = 6'd29, OP_SLL   = 6'd30, OP_SLT   = 6'd31,
    OP_SLTU  = 6'd32, OP_XOR   = 6'd33, OP_SRL   = 6'd34, OP_SRA   = 6'd35,
    OP_OR    = 6'd36, OP_AND   = 6'd37
  } op_e;

endpackage

interface decode_queue_if;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  dec_op_type;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] dec_imm;
  logic [31:0] dec_pc;
  logic        dec_illegal;

  modport slave (
    input  if_valid, if_inst, if_pc, dec_ready,
    output if_ready, dec_valid, dec_op_type, dec_rd, dec_rs1, dec_rs2,
           dec_imm, dec_pc, dec_illegal
  );

  modport master (
    output if_valid, if_inst, if_pc, dec_ready,
    input  if_ready, dec_valid, dec_op_type, dec_rd, dec_rs1, dec_rs2,
           dec_imm, dec_pc, dec_illegal
  );
endinterface

// File: rtl/decode_queue.sv
// RV32I decode stage: DEPTH-entry FIFO of raw {pc, inst} with a combinational
// decoder on the head entry; flush for mispredict recovery and a global freeze.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush_in,
  decode_queue_if.slave bus
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  assign bus.if_ready  = (count_q != FULL_CNT) && rdy_in;
  assign bus.dec_valid = (count_q != '0) && rdy_in && !flush_in;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    push    = bus.if_valid && bus.if_ready && !flush_in;
    pop     = bus.dec_valid && bus.dec_ready;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (rdy_in) begin
      if (flush_in) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) begin
          mem_d[tail_q] = '{pc: bus.if_pc, inst: bus.if_inst};
          tail_d        = tail_q + PTR_ONE;
        end
        if (pop) head_d = head_q + PTR_ONE;
        case ({push, pop})
          2'b10:   count_d = count_q + CNT_ONE;
          2'b01:   count_d = count_q - CNT_ONE;
          default: count_d = count_q;
        endcase
      end
    end
  end

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count_q alone says which entries are live.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  // Head decode
  entry_t          head;
  logic [XLEN-1:0] inst;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  op_e             op;
  fmt_e            fmt;

  assign head   = mem_q[head_q];
  assign inst   = head.inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    op  = OP_NONE;
    fmt = FMT_R;
    case (opcode)
      7'b0110111: begin op = OP_LUI;   fmt = FMT_U; end
      7'b0010111: begin op = OP_AUIPC; fmt = FMT_U; end
      7'b1101111: begin op = OP_JAL;   fmt = FMT_J; end
      7'b1100111: begin
        fmt = FMT_I;
        if (funct3 == 3'b000) op = OP_JALR;
      end
      7'b1100011: begin
        fmt = FMT_B;
        case (funct3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: op = OP_NONE;
        endcase
      end
      7'b0000011: begin
        fmt = FMT_I;
        case (funct3)
          3'b000:  op = OP_LB;
          3'b001:  op = OP_LH;
          3'b010:  op = OP_LW;
          3'b100:  op = OP_LBU;
          3'b101:  op = OP_LHU;
          default: op = OP_NONE;
        endcase
      end
      7'b0100011: begin
        fmt = FMT_S;
        case (funct3)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          3'b010:  op = OP_SW;
          default: op = OP_NONE;
        endcase
      end
      7'b0010011: begin
        fmt = FMT_I;
        case (funct3)
          3'b000: op = OP_ADDI;
          3'b010: op = OP_SLTI;
          3'b011: op = OP_SLTIU;
          3'b100: op = OP_XORI;
          3'b110: op = OP_ORI;
          3'b111: op = OP_ANDI;
          3'b001: begin
            fmt = FMT_SH;
            if (funct7 == 7'b0000000) op = OP_SLLI;
          end
          default: begin
            fmt = FMT_SH;
            if (funct7 == 7'b0000000)      op = OP_SRLI;
            else if (funct7 == 7'b0100000) op = OP_SRAI;
          end
        endcase
      end
      7'b0110011: begin
        fmt = FMT_R;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      op = OP_SUB;
          else if (funct3 == 3'b101) op = OP_SRA;
        end
      end
      default: op = OP_NONE;
    endcase
  end

  // Fields a format does not use, and every field of an illegal entry, read as zero.
  always_comb begin
    bus.dec_rd  = '0;
    bus.dec_rs1 = '0;
    bus.dec_rs2 = '0;
    bus.dec_imm = '0;
    if (op != OP_NONE) begin
      case (fmt)
        FMT_R: begin
          bus.dec_rd  = inst[11:7];
          bus.dec_rs1 = inst[19:15];
          bus.dec_rs2 = inst[24:20];
        end
        FMT_I: begin
          bus.dec_rd  = inst[11:7];
          bus.dec_rs1 = inst[19:15];
          bus.dec_imm = {{20{inst[31]}}, inst[31:20]};
        end
        FMT_SH: begin
          bus.dec_rd  = inst[11:7];
          bus.dec_rs1 = inst[19:15];
          bus.dec_imm = {27'd0, inst[24:20]};
        end
        FMT_S: begin
          bus.dec_rs1 = inst[19:15];
          bus.dec_rs2 = inst[24:20];
          bus.dec_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end
        FMT_B: begin
          bus.dec_rs1 = inst[19:15];
          bus.dec_rs2 = inst[24:20];
          bus.dec_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        end
        FMT_U: begin
          bus.dec_rd  = inst[11:7];
          bus.dec_imm = {inst[31:12], 12'd0};
        end
        FMT_J: begin
          bus.dec_rd  = inst[11:7];
          bus.dec_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        end
        default: bus.dec_imm = '0;
      endcase
    end
  end

  assign bus.dec_op_type = op;
  assign bus.dec_illegal = (op == OP_NONE);
  assign bus.dec_pc      = head.pc;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed decode vectors, full/flush/freeze
// scenarios and random traffic against a queue-based reference model.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk_in   = 1'b0;
  logic rst_in   = 1'b1;
  logic rdy_in   = 1'b1;
  logic flush_in = 1'b0;

  int checks = 0;
  int errors = 0;

  bit [63:0] mq [$];  // {pc, inst}, oldest first

  decode_queue_if bus ();

  decode_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .bus      (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit        ill;
    int        op;
    int        rd;
    int        rs1;
    int        rs2;
    bit [31:0] imm;
  } dec_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode built from opcode tables and integer arithmetic on the word.
  function automatic dec_t ref_decode(input bit [31:0] w);
    dec_t r;
    int   opc = int'(w & 32'h7f);
    int   f3  = int'((w >> 12) & 32'h7);
    int   f7  = int'(w >> 25);
    int   si  = int'(w);
    op_e  br [8] = '{OP_BEQ, OP_BNE, OP_NONE, OP_NONE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    op_e  ld [8] = '{OP_LB, OP_LH, OP_LW, OP_NONE, OP_LBU, OP_LHU, OP_NONE, OP_NONE};
    op_e  st [8] = '{OP_SB, OP_SH, OP_SW, OP_NONE, OP_NONE, OP_NONE, OP_NONE, OP_NONE};
    op_e  ai [8] = '{OP_ADDI, OP_SLLI, OP_SLTI, OP_SLTIU, OP_XORI, OP_SRLI, OP_ORI, OP_ANDI};
    op_e  ar [8] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
    int   rd  = int'((w >> 7) & 32'h1f);
    int   rs1 = int'((w >> 15) & 32'h1f);
    int   rs2 = int'((w >> 20) & 32'h1f);
    r = '{ill: 1'b0, op: 0, rd: 0, rs1: 0, rs2: 0, imm: 32'd0};
    case (opc)
      'h37, 'h17: begin
        r.op = (opc == 'h37) ? OP_LUI : OP_AUIPC;
        r.rd = rd; r.imm = w & 32'hffff_f000;
      end
      'h6f: begin
        r.op = OP_JAL; r.rd = rd;
        r.imm = 32'((si >>> 31) << 20) | ((w >> 12) & 32'hff) << 12
              | ((w >> 20) & 32'h1) << 11 | ((w >> 21) & 32'h3ff) << 1;
      end
      'h67: if (f3 == 0) begin
        r.op = OP_JALR; r.rd = rd; r.rs1 = rs1; r.imm = 32'(si >>> 20);
      end
      'h63: begin
        r.op = br[f3]; r.rs1 = rs1; r.rs2 = rs2;
        r.imm = 32'((si >>> 31) << 12) | ((w >> 7) & 32'h1) << 11
              | ((w >> 25) & 32'h3f) << 5 | ((w >> 8) & 32'hf) << 1;
      end
      'h03: begin
        r.op = ld[f3]; r.rd = rd; r.rs1 = rs1; r.imm = 32'(si >>> 20);
      end
      'h23: begin
        r.op = st[f3]; r.rs1 = rs1; r.rs2 = rs2;
        r.imm = 32'((si >>> 25) << 5) | ((w >> 7) & 32'h1f);
      end
      'h13: begin
        r.rd = rd; r.rs1 = rs1;
        if (f3 == 1 || f3 == 5) begin
          r.imm = (w >> 20) & 32'h1f;
          if (f7 == 0)                  r.op = ai[f3];
          else if (f7 == 32 && f3 == 5) r.op = OP_SRAI;
        end else begin
          r.op = ai[f3]; r.imm = 32'(si >>> 20);
        end
      end
      'h33: begin
        r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        if (f7 == 0)                  r.op = ar[f3];
        else if (f7 == 32 && f3 == 0) r.op = OP_SUB;
        else if (f7 == 32 && f3 == 5) r.op = OP_SRA;
      end
      default: r.op = OP_NONE;
    endcase
    r.ill = (r.op == OP_NONE);
    return r;
  endfunction

  function automatic bit [31:0] rand_inst();
    bit [31:0] w = $urandom();
    bit [6:0]  opcs [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    if ($urandom_range(0, 7) == 0) return w;
    w[6:0] = opcs[$urandom_range(0, 8)];
    if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  // One clock: check outputs against the model at the falling edge, then advance the model.
  task automatic step();
    bit   exp_ir, exp_dv, do_push, do_pop;
    bit   [63:0] ent;
    dec_t r;
    @(negedge clk_in);
    exp_ir = rdy_in && (mq.size() < DEPTH);
    exp_dv = rdy_in && !flush_in && (mq.size() != 0);
    check("if_ready", 32'(bus.if_ready), 32'(exp_ir));
    check("dec_valid", 32'(bus.dec_valid), 32'(exp_dv));
    if (exp_dv) begin
      r = ref_decode(mq[0][31:0]);
      check("dec_pc", bus.dec_pc, mq[0][63:32]);
      check("dec_illegal", 32'(bus.dec_illegal), 32'(r.ill));
      check("dec_op_type", 32'(bus.dec_op_type), 32'(r.op));
      if (!r.ill) begin
        check("dec_rd", 32'(bus.dec_rd), 32'(r.rd));
        check("dec_rs1", 32'(bus.dec_rs1), 32'(r.rs1));
        check("dec_rs2", 32'(bus.dec_rs2), 32'(r.rs2));
        check("dec_imm", bus.dec_imm, r.imm);
      end
    end
    do_push = bus.if_valid && exp_ir && !flush_in;
    do_pop  = exp_dv && bus.dec_ready;
    ent     = {bus.if_pc, bus.if_inst};
    @(posedge clk_in);
    if (rst_in || (rdy_in && flush_in)) begin
      mq.delete();
    end else if (rdy_in) begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(ent);
    end
    #1;
  endtask

  task automatic directed(input string tag, input bit [31:0] w, input bit [31:0] pc,
                          input bit [5:0] op, input bit [4:0] rd, input bit [4:0] rs1,
                          input bit [4:0] rs2, input bit [31:0] imm, input bit ill);
    bus.if_valid = 1'b1; bus.if_inst = w; bus.if_pc = pc; bus.dec_ready = 1'b0;
    step();
    bus.if_valid = 1'b0;
    check({tag, "_valid"}, 32'(bus.dec_valid), 32'd1);
    check({tag, "_op"}, 32'(bus.dec_op_type), 32'(op));
    check({tag, "_illegal"}, 32'(bus.dec_illegal), 32'(ill));
    check({tag, "_pc"}, bus.dec_pc, pc);
    if (!ill) begin
      check({tag, "_rd"}, 32'(bus.dec_rd), 32'(rd));
      check({tag, "_rs1"}, 32'(bus.dec_rs1), 32'(rs1));
      check({tag, "_rs2"}, 32'(bus.dec_rs2), 32'(rs2));
      check({tag, "_imm"}, bus.dec_imm, imm);
    end
    bus.dec_ready = 1'b1;
    step();
    bus.dec_ready = 1'b0;
  endtask

  task automatic drive_rand(input bit valid);
    bus.if_valid = valid;
    bus.if_inst  = rand_inst();
    bus.if_pc    = $urandom() & 32'hffff_fffc;
  endtask

  task automatic drain();
    bus.if_valid  = 1'b0;
    bus.dec_ready = 1'b1;
    repeat (DEPTH + 2) step();
    bus.dec_ready = 1'b0;
  endtask

  initial begin
    bus.if_valid  = 1'b0;
    bus.if_inst   = '0;
    bus.if_pc     = '0;
    bus.dec_ready = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    check("reset_if_ready", 32'(bus.if_ready), 32'd1);
    check("reset_dec_valid", 32'(bus.dec_valid), 32'd0);
    step();

    directed("addi", 32'h0050_0093, 32'h0000_1000, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    directed("bne",  32'hFE20_9EE3, 32'h0000_1004, OP_BNE,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
    directed("lw",   32'h00C1_2283, 32'h0000_1008, OP_LW,   5'd5, 5'd2, 5'd0, 32'd12, 1'b0);
    directed("srai", 32'h4032_5193, 32'h0000_100C, OP_SRAI, 5'd3, 5'd4, 5'd0, 32'd3, 1'b0);
    directed("lui",  32'h1234_53B7, 32'h0000_1010, OP_LUI,  5'd7, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
    directed("ill",  32'h0000_007F, 32'h0000_1014, OP_NONE, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);

    // Fill to DEPTH with consumer stalled; the fifth offer must be held off.
    bus.dec_ready = 1'b0;
    repeat (DEPTH) begin
      drive_rand(1'b1);
      step();
    end
    drive_rand(1'b1);
    check("full_if_ready", 32'(bus.if_ready), 32'd0);
    step();
    // Concurrent push/pop across several pointer wraps.
    bus.dec_ready = 1'b1;
    repeat (20) begin
      step();
      drive_rand(1'b1);
    end
    drain();

    // Flush with three entries buffered and a push offered in the same cycle.
    repeat (3) begin
      drive_rand(1'b1);
      step();
    end
    drive_rand(1'b1);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    bus.if_valid = 1'b0;
    check("flush_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("flush_if_ready", 32'(bus.if_ready), 32'd1);
    bus.dec_ready = 1'b1;
    step();
    check("flush_stays_empty", 32'(bus.dec_valid), 32'd0);

    // Freeze for three cycles in the middle of a stream.
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_rand(1'b1);
      bus.dec_ready = (i % 3) != 0;
      rdy_in = !(i >= 6 && i < 9);
      step();
      if (i == 7) check("frozen_if_ready", 32'(bus.if_ready), 32'd0);
    end
    rdy_in = 1'b1;

    // Reset in mid-stream empties the queue on that edge.
    bus.dec_ready = 1'b0;
    repeat (2) begin
      drive_rand(1'b1);
      step();
    end
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    bus.if_valid = 1'b0;
    check("midreset_dec_valid", 32'(bus.dec_valid), 32'd0);

    // Random traffic including occasional flush and freeze.
    for (int i = 0; i < 400; i++) begin
      drive_rand($urandom_range(0, 3) != 0);
      bus.dec_ready = $urandom_range(0, 3) != 0;
      flush_in      = $urandom_range(0, 39) == 0;
      rdy_in        = $urandom_range(0, 9) != 0;
      step();
    end
    flush_in = 1'b0;
    rdy_in   = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
